seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Multiplexed 7-segment display driver: the display end of the HMI panel logic.
//  It accepts a DIGITS x 8-bit segment frame plus a display mode from the panel
//  state machine, then time-multiplexes the digits onto the shared segment bus.
//  It applies anti-ghost blanking and constant/flash/off modes, and returns
//  flash_cnt so the panel FSM can end its startup flash sequence.
// PARAMETERS
//  DIGITS        5      number of digits; frame width = 8*DIGITS
//  SCAN_DIV      20000  clk cycles per digit slot (1 ms at 20 MHz); must be >= 2
//  BLANK_CYC     20     cycles at slot start with all digits off; must be < SCAN_DIV
//  FLASH_FRAMES  50     full scan frames per flash half-period (on phase = off phase)
// PORTS
//  clk            in   1         system clock
//  reset          in   1         asynchronous reset, active-high
//  data_in        in   8*DIGITS  frame; [8*DIGITS-1 -: 8] = digit 0 (leftmost); bit7 of each byte = dp
//  data_load      in   1         1-cycle strobe: capture data_in into pending buffer
//  seg_mode       in   2         00 constant, 01 flash, 10 off, 11 treated as constant
//  frame_pending  out  1         pending buffer holds a frame not yet shown
//  seg_dig        out  DIGITS    one-hot digit enable, active-high; bit0 = digit 0
//  seg_out        out  8         segment drive, active-high, {dp,g,f,e,d,c,b,a}
//  flash_cnt      out  3         completed flash cycles since flash entry, saturates at 7
// BEHAVIOUR
//  Reset (async): div_cnt=0, dig_idx=0, active frame=0, pending cleared,
//   frame_cnt=0, phase=ON; outputs seg_dig=0, seg_out=0, flash_cnt=0, frame_pending=0.
//  Scan timing
//   - div_cnt counts 0..SCAN_DIV-1.
//   - At div_cnt==SCAN_DIV-1: div_cnt->0 and dig_idx advances; DIGITS-1 wraps to 0.
//   - The wrap marks the frame boundary, so one frame = DIGITS*SCAN_DIV clocks.
//  Outputs are registered, with 1 clk latency from the counter state.
//   - If div_cnt < BLANK_CYC, or display is suppressed: seg_dig=0 and seg_out=0.
//   - Otherwise: seg_dig = 1<<dig_idx and seg_out = active byte[dig_idx].
//   - Display is suppressed when seg_mode==10, or when seg_mode==01 and phase==OFF.
//  Frame buffering (no tearing)
//   - data_load writes the pending buffer and sets frame_pending; a later load overwrites it.
//   - At a frame boundary, a valid pending frame is copied to the active frame and frame_pending clears.
//   - data_load on the boundary cycle: data_in goes straight to active and frame_pending stays 0.
//  Flash (evaluated at frame boundaries, while seg_mode==01)
//   - frame_cnt counts boundaries; at FLASH_FRAMES-1 it resets to 0 and phase toggles.
//   - Each OFF->ON toggle increments flash_cnt, saturating at 7.
//  Mode change
//   - Entering 01 from any other mode sets frame_cnt=0, phase=ON, flash_cnt=0.
//   - Any mode other than 01 holds phase=ON, frame_cnt=0 and flash_cnt=0.
//   - The effect appears on the next clock; the scan position is unaffected.
//  Reset asserted mid-slot or mid-flash returns everything to reset values at once.
//   - The active frame is cleared, so the display is blank until the first frame promotion.
// TESTING (DIGITS=5, SCAN_DIV=4, BLANK_CYC=1, FLASH_FRAMES=2; frame=20 clk)
//  1. Reset, load 40'h73_06_40_06_3F, mode 00.
//     -> frame_pending=1 until the first boundary, then 0.
//     -> Each slot shows 1 blank clk, then seg_dig=00001 with seg_out=8'h73 for 3 clk.
//     -> Next slot shows seg_dig=00010 with seg_out=8'h06; pattern repeats every 20 clk.
//  2. Load A mid-frame, then load B 3 clk later.
//     -> Only B is shown after the boundary; A never appears.
//     -> The displayed frame does not change until the boundary.
//  3. data_load on the exact boundary cycle.
//     -> The new data is shown in the next digit-0 slot and frame_pending stays 0.
//  4. Mode 01 from 00.
//     -> ON for 40 clk, OFF for 40 clk (seg_dig=0).
//     -> flash_cnt steps 1,2,...,7 every 80 clk and stays 7; switching to 00 clears it to 0.
//  5. Mode 10 -> seg_dig=0 and seg_out=0 continuously while scanning continues.
//     -> Returning to 00 resumes the display at the current dig_idx with no restart.
//  6. Assert reset mid-slot during flash.
//     -> All outputs are 0 within the reset cycle and stay blank until a new load is promoted.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with tear-free frame buffering,
// anti-ghost blanking and constant/flash/off display modes.
module seg_scan_driver #(
    parameter int unsigned DIGITS       = 5,
    parameter int unsigned SCAN_DIV     = 20000,
    parameter int unsigned BLANK_CYC    = 20,
    parameter int unsigned FLASH_FRAMES = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*DIGITS-1:0]   data_in,
    input  logic                  data_load,
    input  logic [1:0]            seg_mode,
    output logic                  frame_pending,
    output logic [DIGITS-1:0]     seg_dig,
    output logic [7:0]            seg_out,
    output logic [2:0]            flash_cnt
);

    localparam int unsigned FRAME_W = 8 * DIGITS;
    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FR_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    logic [DIV_W-1:0]   div_cnt;
    logic [IDX_W-1:0]   dig_idx;
    logic [FRAME_W-1:0] active_frame;
    logic [FRAME_W-1:0] pend_frame;
    logic [FR_W-1:0]    frame_cnt;
    phase_t             phase;

    logic       slot_end;
    logic       frame_end;
    logic       flash_mode;
    logic       suppress;
    logic       blank;
    logic [7:0] cur_byte;

    // Scan position decode, display gating and current digit byte select
    always_comb begin
        slot_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
        frame_end  = slot_end && (dig_idx == IDX_W'(DIGITS - 1));
        flash_mode = (seg_mode == 2'b01);
        suppress   = (seg_mode == 2'b10) || (flash_mode && (phase == PH_OFF));
        blank      = (div_cnt < DIV_W'(BLANK_CYC));
        cur_byte   = 8'h00;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dig_idx == IDX_W'(i)) begin
                cur_byte = active_frame[8*(int'(DIGITS)-1-i) +: 8];
            end
        end
    end

    // Slot divider and digit index; the digit wrap is the frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            dig_idx <= (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Pending/active double buffer; promotion only at the frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_frame  <= '0;
            pend_frame    <= '0;
            frame_pending <= 1'b0;
        end else if (frame_end) begin
            if (data_load) begin
                active_frame <= data_in;
            end else if (frame_pending) begin
                active_frame <= pend_frame;
            end
            frame_pending <= 1'b0;
        end else if (data_load) begin
            pend_frame    <= data_in;
            frame_pending <= 1'b1;
        end
    end

    // Flash phase sequencing; held at the ON/zero state outside flash mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            phase     <= PH_ON;
            flash_cnt <= 3'd0;
        end else if (!flash_mode) begin
            frame_cnt <= '0;
            phase     <= PH_ON;
            flash_cnt <= 3'd0;
        end else if (frame_end) begin
            if (frame_cnt == FR_W'(FLASH_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
                if ((phase == PH_OFF) && (flash_cnt != 3'd7)) begin
                    flash_cnt <= flash_cnt + 3'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
            end
        end
    end

    // Registered digit/segment drive with slot-start blanking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_dig <= '0;
            seg_out <= 8'h00;
        end else if (blank || suppress) begin
            seg_dig <= '0;
            seg_out <= 8'h00;
        end else begin
            seg_dig <= DIGITS'(1) << dig_idx;
            seg_out <= cur_byte;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_seg_scan_driver;

    localparam int unsigned DIGITS       = 5;
    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLANK_CYC    = 1;
    localparam int unsigned FLASH_FRAMES = 2;

    localparam logic [39:0] F1 = 40'h73_06_40_06_3F;
    localparam logic [39:0] FA = 40'h11_22_33_44_55;
    localparam logic [39:0] FB = 40'h01_02_04_08_10;
    localparam logic [39:0] FC = 40'h5B_4F_66_6D_7D;
    localparam logic [39:0] FD = 40'h7F_6F_77_7C_39;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [39:0] data_in   = '0;
    logic        data_load = 1'b0;
    logic [1:0]  seg_mode  = 2'b00;
    logic        frame_pending;
    logic [4:0]  seg_dig;
    logic [7:0]  seg_out;
    logic [2:0]  flash_cnt;

    seg_scan_driver #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_load    (data_load),
        .seg_mode     (seg_mode),
        .frame_pending(frame_pending),
        .seg_dig      (seg_dig),
        .seg_out      (seg_out),
        .flash_cnt    (flash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] dig;
        logic [7:0] seg;
        logic       pend;
        logic [2:0] fc;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Clock edges since reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: compare the head expectation when its cycle is presented
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d skipped (now cycle %0d)", q[0].nm, q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            n_checks++;
            if (seg_dig === q[0].dig && seg_out === q[0].seg &&
                frame_pending === q[0].pend && flash_cnt === q[0].fc) begin
                n_pass++;
            end else begin
                $display("FAIL %s cyc=%0d: got dig=%b seg=%h pend=%b fc=%0d, want dig=%b seg=%h pend=%b fc=%0d",
                         q[0].nm, cyc, seg_dig, seg_out, frame_pending, flash_cnt,
                         q[0].dig, q[0].seg, q[0].pend, q[0].fc);
            end
            void'(q.pop_front());
        end
    end

    task automatic push(input int c, input logic [4:0] d, input logic [7:0] s,
                        input logic p, input logic [2:0] f, input string nm);
        exp_t e;
        e.cyc = c; e.dig = d; e.seg = s; e.pend = p; e.fc = f; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_at(input int e, input logic [39:0] d);
        wait_cyc(e - 1);
        data_in   = d;
        data_load = 1'b1;
        wait_cyc(e);
        data_load = 1'b0;
    endtask

    task automatic mode_at(input int e, input logic [1:0] m);
        wait_cyc(e - 1);
        seg_mode = m;
    endtask

    task automatic apply_reset(input bit do_load, input logic [39:0] d, input logic [1:0] m);
        reset     = 1'b1;
        data_load = 1'b0;
        seg_mode  = m;
        push(0, 5'b00000, 8'h00, 1'b0, 3'd0, "reset");
        repeat (2) @(negedge clk);
        n_checks++;
        if (seg_dig === 5'b00000) n_pass++;
        else $display("FAIL in_reset_dig: got %b", seg_dig);
        n_checks++;
        if (seg_out === 8'h00) n_pass++;
        else $display("FAIL in_reset_seg: got %h", seg_out);
        n_checks++;
        if (flash_cnt === 3'd0) n_pass++;
        else $display("FAIL in_reset_fc: got %0d", flash_cnt);
        n_checks++;
        if (frame_pending === 1'b0) n_pass++;
        else $display("FAIL in_reset_pend: got %b", frame_pending);
        #1;
        data_in   = d;
        data_load = do_load;
        reset     = 1'b0;
        wait_cyc(1);
        data_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic scan, first promotion at the edge-20 boundary
        push(1,  5'b00000, 8'h00, 1'b1, 3'd0, "t1_first_blank");
        push(2,  5'b00001, 8'h00, 1'b1, 3'd0, "t1_empty_active");
        push(19, 5'b10000, 8'h00, 1'b1, 3'd0, "t1_pending_held");
        push(20, 5'b10000, 8'h00, 1'b0, 3'd0, "t1_boundary");
        push(21, 5'b00000, 8'h00, 1'b0, 3'd0, "t1_slot_blank");
        push(22, 5'b00001, 8'h73, 1'b0, 3'd0, "t1_dig0");
        push(24, 5'b00001, 8'h73, 1'b0, 3'd0, "t1_dig0_last");
        push(26, 5'b00010, 8'h06, 1'b0, 3'd0, "t1_dig1");
        push(30, 5'b00100, 8'h40, 1'b0, 3'd0, "t1_dig2");
        push(34, 5'b01000, 8'h06, 1'b0, 3'd0, "t1_dig3");
        push(38, 5'b10000, 8'h3F, 1'b0, 3'd0, "t1_dig4");
        push(41, 5'b00000, 8'h00, 1'b0, 3'd0, "t1_wrap_blank");
        push(42, 5'b00001, 8'h73, 1'b0, 3'd0, "t1_repeat");
        // Overwritten pending frame, no tearing
        push(46, 5'b00010, 8'h06, 1'b1, 3'd0, "t2_old_after_a");
        push(50, 5'b00100, 8'h40, 1'b1, 3'd0, "t2_old_after_b");
        push(59, 5'b10000, 8'h3F, 1'b1, 3'd0, "t2_old_last");
        push(60, 5'b10000, 8'h3F, 1'b0, 3'd0, "t2_boundary");
        push(62, 5'b00001, 8'h01, 1'b0, 3'd0, "t2_b_dig0");
        push(66, 5'b00010, 8'h02, 1'b0, 3'd0, "t2_b_dig1");
        push(78, 5'b10000, 8'h10, 1'b0, 3'd0, "t2_b_dig4");
        // Load on the boundary cycle
        push(80, 5'b10000, 8'h10, 1'b0, 3'd0, "t3_boundary");
        push(81, 5'b00000, 8'h00, 1'b0, 3'd0, "t3_no_pending");
        push(82, 5'b00001, 8'h5B, 1'b0, 3'd0, "t3_c_dig0");
        push(86, 5'b00010, 8'h4F, 1'b0, 3'd0, "t3_c_dig1");
        // Flash mode
        push(90,  5'b00100, 8'h66, 1'b0, 3'd0, "t4_enter_on");
        push(119, 5'b10000, 8'h7D, 1'b0, 3'd0, "t4_last_on");
        push(122, 5'b00000, 8'h00, 1'b0, 3'd0, "t4_off1");
        push(142, 5'b00000, 8'h00, 1'b0, 3'd0, "t4_off2");
        push(159, 5'b00000, 8'h00, 1'b0, 3'd0, "t4_off_end");
        push(160, 5'b00000, 8'h00, 1'b0, 3'd1, "t4_fc1");
        push(162, 5'b00001, 8'h5B, 1'b0, 3'd1, "t4_on2");
        push(202, 5'b00000, 8'h00, 1'b0, 3'd1, "t4_off_again");
        push(240, 5'b00000, 8'h00, 1'b0, 3'd2, "t4_fc2");
        push(242, 5'b00001, 8'h5B, 1'b0, 3'd2, "t4_on3");
        push(640, 5'b00000, 8'h00, 1'b0, 3'd7, "t4_fc7");
        push(682, 5'b00000, 8'h00, 1'b0, 3'd7, "t4_off_fc7");
        push(722, 5'b00001, 8'h5B, 1'b0, 3'd7, "t4_sat1");
        push(802, 5'b00001, 8'h5B, 1'b0, 3'd7, "t4_sat2");
        push(805, 5'b00000, 8'h00, 1'b0, 3'd0, "t4_exit_clear");
        push(806, 5'b00010, 8'h4F, 1'b0, 3'd0, "t4_const_again");
        // Off mode, scan keeps running
        push(810, 5'b00000, 8'h00, 1'b0, 3'd0, "t5_off_a");
        push(815, 5'b00000, 8'h00, 1'b0, 3'd0, "t5_off_b");
        push(830, 5'b00000, 8'h00, 1'b0, 3'd0, "t5_off_c");
        push(842, 5'b00001, 8'h5B, 1'b0, 3'd0, "t5_resume_dig0");
        push(847, 5'b00010, 8'h4F, 1'b0, 3'd0, "t5_resume_dig1");
        // Flash again, ahead of the mid-slot reset
        push(852, 5'b00100, 8'h66, 1'b0, 3'd0, "t6_flash_on");
        push(884, 5'b00000, 8'h00, 1'b0, 3'd0, "t6_flash_off");

        apply_reset(1'b1, F1, 2'b00);
        load_at(45, FA);
        load_at(48, FB);
        load_at(80, FC);
        mode_at(90, 2'b01);
        mode_at(805, 2'b00);
        mode_at(810, 2'b10);
        mode_at(842, 2'b00);
        mode_at(850, 2'b01);
        wait_cyc(885);

        // Mid-slot reset during flash: active frame lost until next promotion
        apply_reset(1'b0, '0, 2'b01);
        n_checks++;
        if (seg_dig === 5'b00000 && seg_out === 8'h00) n_pass++;
        else $display("FAIL t6_release_blank: got dig=%b seg=%h", seg_dig, seg_out);
        n_checks++;
        if (frame_pending === 1'b0 && flash_cnt === 3'd0) n_pass++;
        else $display("FAIL t6_release_state: got pend=%b fc=%0d", frame_pending, flash_cnt);
        push(2,  5'b00001, 8'h00, 1'b0, 3'd0, "t6_post_reset_empty");
        push(6,  5'b00010, 8'h00, 1'b1, 3'd0, "t6_pending");
        push(20, 5'b10000, 8'h00, 1'b0, 3'd0, "t6_promote");
        push(22, 5'b00001, 8'h7F, 1'b0, 3'd0, "t6_d_dig0");
        push(26, 5'b00010, 8'h6F, 1'b0, 3'd0, "t6_d_dig1");
        push(42, 5'b00000, 8'h00, 1'b0, 3'd0, "t6_flash_off");
        load_at(5, FD);

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        #1;
        while (q.size() > 0) begin
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d never checked", q[0].nm, q[0].cyc);
            void'(q.pop_front());
        end
        if (n_pass != n_checks) $display("FAIL summary: %0d of %0d checks failed", n_checks - n_pass, n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
